// File: rtl/enc_pkg.sv
// Shared defaults and state encoding for the encoder hypervector assembler.
package enc_pkg;

  localparam int ENC_HV_DIM      = 5000;
  localparam int ENC_DIMS_PER_CC = 500;

  typedef enum logic {
    FILL = 1'b0,
    DONE = 1'b1
  } enc_asm_state_t;

endpackage

// File: rtl/enc_hv_assembler.sv
// Collects DIMS_PER_CC-bit thresholded chunks into one HV_DIM-bit hypervector and
// hands it to the associative memory with a valid/ready handshake.
module enc_hv_assembler
  import enc_pkg::*;
#(
  parameter int  HV_DIM      = ENC_HV_DIM,
  parameter int  DIMS_PER_CC = ENC_DIMS_PER_CC,
  parameter int  CNT_W       = 16,
  localparam int NUM_CHUNKS  = (HV_DIM + DIMS_PER_CC - 1) / DIMS_PER_CC,
  localparam int LAST_W      = HV_DIM - (NUM_CHUNKS - 1) * DIMS_PER_CC,
  localparam int CTR_W       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIMS_PER_CC-1:0] in_bits,
  output logic [CTR_W-1:0]       chunk_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [HV_DIM-1:0]      encoded_hv,
  output logic [CNT_W-1:0]       hv_count
);

  localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(NUM_CHUNKS - 1);

  enc_asm_state_t state;
  logic           beat;

  // Handshake outputs decode straight from the state register.
  assign in_ready  = (state == FILL);
  assign out_valid = (state == DONE);
  assign beat      = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      chunk_idx <= '0;
      hv_count  <= '0;
    end else if (flush) begin
      state     <= FILL;
      chunk_idx <= '0;
    end else if (beat) begin
      if (chunk_idx == LAST_IDX) begin
        chunk_idx <= '0;
        state     <= DONE;
      end else begin
        chunk_idx <= chunk_idx + CTR_W'(1);
      end
    end else if (out_valid && out_ready) begin
      hv_count <= hv_count + CNT_W'(1);
      state    <= FILL;
    end
  end

  // One register slice per chunk, enabled by a decode of chunk_idx; the final
  // slice is only LAST_W wide so any surplus bits of the last beat are dropped.
  for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_chunk
    localparam int W = (k == NUM_CHUNKS - 1) ? LAST_W : DIMS_PER_CC;

    logic         wr_en;
    logic [W-1:0] chunk_q;

    assign wr_en = beat && (chunk_idx == CTR_W'(k));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        chunk_q <= '0;
      end else if (flush) begin
        chunk_q <= '0;
      end else if (wr_en) begin
        chunk_q <= in_bits[W-1:0];
      end
    end

    assign encoded_hv[k*DIMS_PER_CC +: W] = chunk_q;
  end

  if (LAST_W < DIMS_PER_CC) begin : g_ragged
    logic unused_hi;
    assign unused_hi = ^in_bits[DIMS_PER_CC-1:LAST_W];
  end

endmodule

// File: tb/tb_enc_hv_assembler.sv
// Directed bench for enc_hv_assembler: a default-sized instance and a small
// ragged instance (HV_DIM=10, DIMS_PER_CC=4, CNT_W=2).
module tb_enc_hv_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-sized instance
  logic          rst_b, flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [499:0]  in_bits_b;
  logic [3:0]    idx_b;
  logic [4999:0] hv_b;
  logic [15:0]   cnt_b;

  // Small ragged instance
  logic          rst_s, flush_s, in_valid_s, in_ready_s, out_valid_s, out_ready_s;
  logic [3:0]    in_bits_s;
  logic [1:0]    idx_s;
  logic [9:0]    hv_s;
  logic [1:0]    cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  enc_hv_assembler dut_big (
    .clk(clk), .rst(rst_b), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_bits(in_bits_b),
    .chunk_idx(idx_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .encoded_hv(hv_b), .hv_count(cnt_b)
  );

  enc_hv_assembler #(.HV_DIM(10), .DIMS_PER_CC(4), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst_s), .flush(flush_s),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .in_bits(in_bits_s),
    .chunk_idx(idx_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .encoded_hv(hv_s), .hv_count(cnt_s)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected big HV: chunk k is all ones when k[0]^inv, else all zeros
  function automatic logic [4999:0] big_pattern(input bit inv);
    logic [4999:0] v;
    v = '0;
    for (int k = 0; k < 10; k++) begin
      if ((k % 2 == 1) ^ inv) v[k*500 +: 500] = '1;
    end
    return v;
  endfunction

  task automatic fill_big(input bit inv);
    for (int k = 0; k < 10; k++) begin
      bit b;
      b = (k % 2 == 1) ^ inv;
      in_valid_b = 1'b1;
      in_bits_b  = {500{b}};
      tick();
    end
    in_valid_b = 1'b0;
  endtask

  task automatic fill_small(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    in_valid_s = 1'b1;
    in_bits_s = a; tick();
    in_bits_s = b; tick();
    in_bits_s = c; tick();
    in_valid_s = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++; if (in_ready_b !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready_big: got %b expected 1", in_ready_b); end
    n_checks++; if (out_valid_b !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid_big: got %b expected 0", out_valid_b); end
    n_checks++; if (idx_b !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_chunk_idx_big: got %0d expected 0", idx_b); end
    n_checks++; if (hv_b !== '0) begin n_fail++; $display("[TB] FAIL reset_hv_big: %0d bits set, expected 0", $countones(hv_b)); end
    n_checks++; if (cnt_b !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_count_big: got %0d expected 0", cnt_b); end
    n_checks++; if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_handshake_small: in_ready %b out_valid %b expected 1 0", in_ready_s, out_valid_s); end
    n_checks++; if (hv_s !== 10'h000 || cnt_s !== 2'd0 || idx_s !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_state_small: hv %h count %0d idx %0d expected 0 0 0", hv_s, cnt_s, idx_s); end
  endtask

  task automatic test_full_hv;
    logic [4999:0] exp_hv;
    exp_hv = big_pattern(1'b0);
    out_ready_b = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bit b;
      b = (k % 2 == 1);
      n_checks++; if (idx_b !== 4'(k)) begin n_fail++; $display("[TB] FAIL full_chunk_idx: got %0d expected %0d", idx_b, k); end
      in_valid_b = 1'b1;
      in_bits_b  = {500{b}};
      tick();
    end
    in_valid_b = 1'b0;
    n_checks++; if (out_valid_b !== 1'b1 || in_ready_b !== 1'b0) begin n_fail++; $display("[TB] FAIL full_done_flags: out_valid %b in_ready %b expected 1 0", out_valid_b, in_ready_b); end
    n_checks++; if (hv_b !== exp_hv) begin n_fail++; $display("[TB] FAIL full_hv: %0d bits differ from expected pattern", $countones(hv_b ^ exp_hv)); end
    n_checks++; if (cnt_b !== 16'd0) begin n_fail++; $display("[TB] FAIL full_count_before: got %0d expected 0", cnt_b); end
    tick();
    n_checks++; if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin n_fail++; $display("[TB] FAIL full_bubble_flags: out_valid %b in_ready %b expected 0 1", out_valid_b, in_ready_b); end
    n_checks++; if (cnt_b !== 16'd1) begin n_fail++; $display("[TB] FAIL full_count_after: got %0d expected 1", cnt_b); end
  endtask

  task automatic test_flush;
    logic [4999:0] exp_hv;
    exp_hv = big_pattern(1'b1);
    out_ready_b = 1'b1;
    in_valid_b  = 1'b1;
    in_bits_b   = '1;
    repeat (4) tick();
    n_checks++; if (idx_b !== 4'd4) begin n_fail++; $display("[TB] FAIL flush_pre_idx: got %0d expected 4", idx_b); end
    flush_b = 1'b1;
    tick();
    flush_b    = 1'b0;
    in_valid_b = 1'b0;
    n_checks++; if (idx_b !== 4'd0) begin n_fail++; $display("[TB] FAIL flush_idx: got %0d expected 0", idx_b); end
    n_checks++; if (hv_b !== '0) begin n_fail++; $display("[TB] FAIL flush_hv: %0d bits set, expected 0", $countones(hv_b)); end
    n_checks++; if (out_valid_b !== 1'b0 || cnt_b !== 16'd1) begin n_fail++; $display("[TB] FAIL flush_state: out_valid %b count %0d expected 0 1", out_valid_b, cnt_b); end
    fill_big(1'b1);
    n_checks++; if (out_valid_b !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_refill_valid: got %b expected 1", out_valid_b); end
    n_checks++; if (hv_b !== exp_hv) begin n_fail++; $display("[TB] FAIL flush_refill_hv: %0d bits differ from expected pattern", $countones(hv_b ^ exp_hv)); end
    tick();
    n_checks++; if (cnt_b !== 16'd2) begin n_fail++; $display("[TB] FAIL flush_refill_count: got %0d expected 2", cnt_b); end
  endtask

  task automatic test_async_reset;
    out_ready_b = 1'b0;
    fill_big(1'b1);
    n_checks++; if (out_valid_b !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_pre_valid: got %b expected 1", out_valid_b); end
    #3 rst_b = 1'b1;
    #1;
    n_checks++; if (out_valid_b !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_out_valid: got %b expected 0", out_valid_b); end
    n_checks++; if (hv_b !== '0) begin n_fail++; $display("[TB] FAIL areset_hv: %0d bits set, expected 0", $countones(hv_b)); end
    n_checks++; if (cnt_b !== 16'd0) begin n_fail++; $display("[TB] FAIL areset_count: got %0d expected 0", cnt_b); end
    #1 rst_b = 1'b0;
    tick();
    n_checks++; if (in_ready_b !== 1'b1 || idx_b !== 4'd0) begin n_fail++; $display("[TB] FAIL areset_release: in_ready %b idx %0d expected 1 0", in_ready_b, idx_b); end
  endtask

  task automatic test_ragged;
    out_ready_s = 1'b1;
    fill_small(4'hA, 4'h5, 4'hF);
    n_checks++; if (out_valid_s !== 1'b1 || in_ready_s !== 1'b0) begin n_fail++; $display("[TB] FAIL ragged_flags: out_valid %b in_ready %b expected 1 0", out_valid_s, in_ready_s); end
    n_checks++; if (hv_s !== 10'h35A) begin n_fail++; $display("[TB] FAIL ragged_hv: got %h expected 35a", hv_s); end
    tick();
    n_checks++; if (cnt_s !== 2'd1 || in_ready_s !== 1'b1) begin n_fail++; $display("[TB] FAIL ragged_handoff: count %0d in_ready %b expected 1 1", cnt_s, in_ready_s); end
  endtask

  task automatic test_back_to_back;
    out_ready_s = 1'b0;
    fill_small(4'h1, 4'h2, 4'h3);
    in_valid_s = 1'b1;
    in_bits_s  = 4'hC;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid_s !== 1'b1 || in_ready_s !== 1'b0 || idx_s !== 2'd0 || hv_s !== 10'h321) begin
        n_fail++;
        $display("[TB] FAIL stall_hold[%0d]: out_valid %b in_ready %b idx %0d hv %h expected 1 0 0 321", i, out_valid_s, in_ready_s, idx_s, hv_s);
      end
      tick();
    end
    in_valid_s  = 1'b0;
    out_ready_s = 1'b1;
    tick();
    n_checks++; if (cnt_s !== 2'd2 || out_valid_s !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_release: count %0d out_valid %b expected 2 0", cnt_s, out_valid_s); end
    tick();
    n_checks++; if (cnt_s !== 2'd2) begin n_fail++; $display("[TB] FAIL stall_single_count: got %0d expected 2", cnt_s); end
  endtask

  task automatic test_flush_done;
    out_ready_s = 1'b1;
    fill_small(4'h7, 4'h8, 4'h9);
    n_checks++; if (hv_s !== 10'h187) begin n_fail++; $display("[TB] FAIL flushdone_pre_hv: got %h expected 187", hv_s); end
    flush_s = 1'b1;
    tick();
    flush_s = 1'b0;
    n_checks++; if (out_valid_s !== 1'b0 || cnt_s !== 2'd2 || hv_s !== 10'h000) begin
      n_fail++;
      $display("[TB] FAIL flushdone_state: out_valid %b count %0d hv %h expected 0 2 000", out_valid_s, cnt_s, hv_s);
    end
  endtask

  task automatic test_count_wrap;
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_s = 1'b1;
    #2 rst_s = 1'b0;
    out_ready_s = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      fill_small(4'hF, 4'h0, 4'hC);
      tick();
      n_checks++; if (cnt_s !== exp_cnt[i]) begin n_fail++; $display("[TB] FAIL wrap_count[%0d]: got %0d expected %0d", i, cnt_s, exp_cnt[i]); end
    end
  endtask

  initial begin
    rst_b = 1'b1; flush_b = 1'b0; in_valid_b = 1'b0; in_bits_b = '0; out_ready_b = 1'b0;
    rst_s = 1'b1; flush_s = 1'b0; in_valid_s = 1'b0; in_bits_s = '0; out_ready_s = 1'b0;
    repeat (2) tick();
    rst_b = 1'b0;
    rst_s = 1'b0;
    tick();
    test_reset();
    test_full_hv();
    test_flush();
    test_async_reset();
    test_ragged();
    test_back_to_back();
    test_flush_done();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enc_hv_assembler.md
Name: enc_hv_assembler

Overview:
- Parametrised successor of the encoder output register.
- Assembles an HV_DIM-bit encoded hypervector from DIMS_PER_CC-bit thresholded chunks, one chunk per accepted beat, using an internal chunk counter.
- Adds valid/ready handshakes on both sides, ragged last-chunk support, synchronous flush and a completed-HV counter.
- Sits between the thresholding stage and the associative-memory / classifier input.

Parameters:
- HV_DIM, 5000, hypervector width in bits.
- DIMS_PER_CC, 500, chunk width delivered per beat.
- NUM_CHUNKS, ceil(HV_DIM/DIMS_PER_CC) (localparam, derived), chunks per HV.
- LAST_W, HV_DIM-(NUM_CHUNKS-1)*DIMS_PER_CC (localparam, derived), valid bits in the final chunk.
- CTR_W, max(1,$clog2(NUM_CHUNKS)) (localparam), chunk counter width.
- CNT_W, 16, width of completed-HV counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- flush  in  1  synchronous abort of the HV being assembled.
- in_valid  in  1  chunk valid.
- in_ready  out  1  block can accept a chunk.
- in_bits  in  DIMS_PER_CC  thresholded chunk.
- chunk_idx  out  CTR_W  index of the next chunk to be written.
- out_valid  out  1  encoded_hv complete and stable.
- out_ready  in  1  consumer accepts encoded_hv.
- encoded_hv  out  HV_DIM  assembled hypervector.
- hv_count  out  CNT_W  number of HVs handed off since reset.

Interface fixed: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (rst=1, async):
  - state=FILL, chunk_idx=0, encoded_hv='0, out_valid=0, hv_count=0.
  - in_ready=1 as soon as reset releases.
- States: FILL, DONE (enumerated in package).
- FILL:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid&&in_ready.
  - On a beat with chunk_idx=k<NUM_CHUNKS-1: encoded_hv[k*DIMS_PER_CC +: DIMS_PER_CC] <= in_bits; chunk_idx <= k+1.
  - On a beat with k=NUM_CHUNKS-1: write in_bits[LAST_W-1:0] to encoded_hv[HV_DIM-1 -: LAST_W]; in_bits[DIMS_PER_CC-1:LAST_W] are ignored; chunk_idx <= 0; state <= DONE.
  - Bits of encoded_hv not yet written in the current HV hold their previous value; no clearing between HVs.
- DONE:
  - out_valid=1, in_ready=0; encoded_hv stable.
  - in_valid is ignored and nothing is written.
  - On out_valid&&out_ready: hv_count <= hv_count+1 (wraps modulo 2^CNT_W); state <= FILL next cycle.
  - No same-cycle pass-through: one bubble cycle per HV.
- Latency: out_valid rises the cycle after the last chunk is accepted. Minimum period is NUM_CHUNKS+1 cycles per HV.
- flush, sampled synchronously, has priority over all handshakes in either state:
  - Next cycle: state=FILL, chunk_idx=0, encoded_hv='0, out_valid=0.
  - hv_count unchanged; a handshake coinciding with flush does not count.
  - A beat coinciding with flush is dropped.
- NUM_CHUNKS=1: every accepted beat goes directly to DONE.
- rst mid-assembly: all state returns to reset values immediately, regardless of clk.
- Outputs are registered except in_ready and out_valid, which decode directly from the state register (no combinational path from inputs).
- Write-enable per chunk is a decode of chunk_idx. Synthesises to NUM_CHUNKS enables, no barrel shifter.

Decomposition:
- Package enc_pkg: HV_DIM and DIMS_PER_CC defaults, and the state enum typedef enc_asm_state_t {FILL, DONE}.
- NUM_CHUNKS, LAST_W and CTR_W are derived localparams inside the module.
- No sub-module; the chunk counter and write decode stay inline.

Test Plan:
- Defaults, 10 back-to-back beats with in_bits={500{k[0]}} for k=0..9, out_ready=1 → out_valid on cycle 11; encoded_hv = alternating 500-bit zero/one blocks starting with zeros at [499:0]; hv_count=1; in_ready high again on cycle 12.
- HV_DIM=10, DIMS_PER_CC=4, beats 4'hA, 4'h5, 4'hF → encoded_hv=10'b11_0101_1010; upper 2 bits of the third beat discarded; NUM_CHUNKS=3.
- Complete HV, out_ready=0 for 5 cycles while in_valid=1 with new data → out_valid held, encoded_hv unchanged, in_ready=0, chunk_idx=0; then out_ready=1 → hv_count increments once.
- flush asserted with chunk_idx=4 and in_valid=1 → next cycle chunk_idx=0, encoded_hv=0, beat dropped; a following full HV assembles correctly.
- rst pulsed asynchronously in DONE mid-cycle → out_valid, encoded_hv and hv_count read 0 before the next clk edge.
- CNT_W=2, five full handoffs → hv_count sequence 1,2,3,0,1.
